// File: rtl/popcount_pattern_gen.sv
// popcount_pattern_gen: enumerates, in ascending order, every W-bit word that
// holds exactly k ones. One word per valid/ready handshake, done pulse after
// the final word is accepted.
// Optional build macro PATTERN_SELFCHECK_EN adds the chk_err output and the
// popcount/ordering monitor behind it.
module popcount_pattern_gen #(
  parameter int W  = 4,
  parameter int CW = $clog2(W+1),
  parameter int IW = $clog2(2**W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] k_in,
  output logic          busy,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [IW-1:0] out_index,
  output logic          done
`ifdef PATTERN_SELFCHECK_EN
  ,
  output logic          chk_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] k_reg;

  // Gosper step operands, one bit wider than the word so the carry out of
  // the top bit is not lost before the final truncation.
  logic [W:0]    x_ext;
  logic [W:0]    c_ext;
  logic [W:0]    r_ext;
  logic [CW-1:0] tz;
  logic [W-1:0]  next_pat;
  logic [W-1:0]  first_pat;
  logic [W-1:0]  kmask;
  logic [W-1:0]  last_pat;
  logic          accept;

  // Trailing-zero count of the current word (priority scan, no divider).
  always_comb begin
    tz = '0;
    for (int i = W-1; i >= 0; i--) begin
      if (out_data[i]) tz = CW'(i);
    end
  end

  assign x_ext    = {1'b0, out_data};
  assign c_ext    = x_ext & (~x_ext + (W+1)'(1));
  assign r_ext    = x_ext + c_ext;
  assign next_pat = W'(r_ext | (((r_ext ^ x_ext) >> 2) >> tz));

  // Smallest word for the requested k, and the largest word for latched k.
  assign first_pat = W'(((W+1)'(1) << k_in) - (W+1)'(1));
  assign kmask     = W'(((W+1)'(1) << k_reg) - (W+1)'(1));
  assign last_pat  = kmask << (W - int'(k_reg));

  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_RUN);
  // Gated by out_valid so the stale word left in DONE/IDLE never flags last.
  assign out_last  = out_valid && (out_data == last_pat);
  assign accept    = out_valid && out_ready;

  // Control FSM and output word/index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_reg     <= '0;
      out_data  <= '0;
      out_index <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (int'(k_in) > W) begin
              err <= 1'b1;
            end else begin
              k_reg     <= k_in;
              out_data  <= first_pat;
              out_index <= '0;
              state     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (out_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              out_data  <= next_pat;
              out_index <= out_index + IW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PATTERN_SELFCHECK_EN
  logic [CW-1:0] pc;

  // Ones count of the word currently presented.
  always_comb begin
    pc = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + CW'(out_data[i]);
    end
  end

  // Sticky monitor: wrong popcount or a non-increasing successor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (state == S_IDLE && start && int'(k_in) <= W) begin
      chk_err <= 1'b0;
    end else if (out_valid) begin
      if (pc != k_reg) chk_err <= 1'b1;
      if (accept && !out_last && next_pat <= out_data) chk_err <= 1'b1;
    end
  end
`endif

endmodule
